// File: rtl/imem_bootload_pkg.sv
// Shared types and helpers for the boot-loadable instruction memory.
package imem_pkg;

   // Top-level operating modes.
   typedef enum logic [1:0] {
      RUN   = 2'd0,
      LOAD  = 2'd1,
      FLUSH = 2'd2
   } state_t;

   // addi x0,x0,0 : canonical RISC-V NOP, used as power-up fill and fault filler.
   localparam logic [31:0] NOP = 32'h0000_0013;

   // Number of bytes that make up one instruction word.
   function automatic int bytes_per_word(input int ins_w);
      return ins_w / 8;
   endfunction

endpackage

// File: rtl/imem_bootload_byte_packer.sv
// Assembles little-endian bytes into instruction words for the load port.
module imem_byte_packer
   import imem_pkg::*;
#(
   parameter int INS_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             accept,
   input  logic             flush,
   input  logic [7:0]       byte_in,
   output logic [INS_W-1:0] word,
   output logic             word_done,
   output logic             pending
);

   localparam int BPW = bytes_per_word(INS_W);
   localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
   localparam logic [BW-1:0] LAST = BW'(BPW - 1);

   logic [BW-1:0]    idx;
   logic [INS_W-1:0] acc;

   // Merge the byte being accepted this cycle into its lane of the word.
   always_comb begin
      word = acc;
      if (accept) begin
         word[{idx, 3'b000} +: 8] = byte_in;
      end else begin
         word = acc;
      end
   end

   assign word_done = accept && (idx == LAST);
   assign pending   = (idx != '0);

   // Byte index and accumulator; a finished or flushed word restarts from a zeroed lane set.
   always_ff @(posedge clk) begin
      if (rst || clear || flush || word_done) begin
         idx <= '0;
         acc <= '0;
      end else if (accept) begin
         idx <= idx + BW'(1);
         acc <= word;
      end else begin
         idx <= idx;
         acc <= acc;
      end
   end

endmodule

// File: rtl/imem_bootload.sv
// Instruction memory with registered fetch port and byte-serial boot-load port.
module imem_bootload
   import imem_pkg::*;
#(
   parameter int                 INS_ADDRESS = 9,
   parameter int                 INS_W       = 32,
   parameter int                 DEPTH       = 2 ** (INS_ADDRESS - 2),
   parameter logic [INS_W-1:0]   INIT_WORD   = INS_W'(NOP)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ld_en,
   input  logic                   ld_valid,
   input  logic [7:0]             ld_byte,
   output logic                   ld_ready,
   output logic [INS_ADDRESS-2:0] ld_count,
   output logic                   ld_full,
   input  logic                   req,
   input  logic [INS_ADDRESS-1:0] ra,
   output logic [INS_W-1:0]       rd,
   output logic                   rd_valid,
   output logic                   fault,
   output logic                   busy
);

   localparam int CW = INS_ADDRESS - 1;
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   state_t state, next_state;
   logic [CW-1:0]    cnt;
   logic             full;
   logic [INS_W-1:0] mem [DEPTH] = '{default: INIT_WORD};

   logic             accept, pending, pending_after;
   logic             word_done;
   logic [INS_W-1:0] word;
   logic             we;
   logic [AW-1:0]    waddr;

   logic [INS_ADDRESS-3:0] widx;
   logic                   bad_fetch;

   assign ld_ready = (state == LOAD) && !full;
   assign accept   = ld_valid && ld_ready;
   assign ld_count = cnt;
   assign ld_full  = full;
   assign busy     = (state != RUN);

   imem_byte_packer #(.INS_W(INS_W)) u_packer (
      .clk       (clk),
      .rst       (rst),
      .clear     (state == RUN),
      .accept    (accept),
      .flush     (state == FLUSH),
      .byte_in   (ld_byte),
      .word      (word),
      .word_done (word_done),
      .pending   (pending)
   );

   // A byte accepted on the same cycle ld_en drops still decides whether a flush is needed.
   assign pending_after = accept ? !word_done : pending;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state = state;
      case (state)
         RUN:     if (ld_en) next_state = LOAD; else next_state = RUN;
         LOAD: begin
            if (!ld_en) begin
               next_state = pending_after ? FLUSH : RUN;
            end else begin
               next_state = LOAD;
            end
         end
         FLUSH:   next_state = RUN;
         default: next_state = RUN;
      endcase
   end

   // Write pointer / word counter and full flag; cleared on every entry into LOAD.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         full <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (ld_en) begin
                  cnt  <= '0;
                  full <= 1'b0;
               end
            end
            LOAD: begin
               if (word_done) begin
                  cnt <= cnt + CW'(1);
                  if ((cnt + CW'(1)) == DEPTH_C) full <= 1'b1;
               end
            end
            FLUSH:   cnt <= cnt + CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Array write enable: completed words in LOAD, the zero-padded partial word in FLUSH.
   always_comb begin
      we    = 1'b0;
      waddr = cnt[AW-1:0];
      if ((state == LOAD && word_done) || state == FLUSH) begin
         we = 1'b1;
      end else begin
         we = 1'b0;
      end
   end

   // Instruction array; contents survive rst.
   always_ff @(posedge clk) begin
      if (!rst && we) begin
         mem[waddr] <= word;
      end
   end

   assign widx      = ra[INS_ADDRESS-1:2];
   assign bad_fetch = (ra[1:0] != 2'b00) || ({1'b0, widx} >= DEPTH_C);

   // Registered fetch port; only live in RUN, and a rising ld_en drops the request.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd       <= '0;
         rd_valid <= 1'b0;
         fault    <= 1'b0;
      end else if (state == RUN && !ld_en && req) begin
         rd_valid <= 1'b1;
         fault    <= bad_fetch;
         rd       <= bad_fetch ? INIT_WORD : mem[widx[AW-1:0]];
      end else begin
         rd_valid <= 1'b0;
         fault    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_imem_bootload.sv
// Scoreboard bench for imem_bootload (DEPTH reduced to 16 to reach range limits quickly).
module tb_imem_bootload;

   localparam int IA = 9;
   localparam int W  = 32;
   localparam int D  = 16;

   logic          clk = 1'b0;
   logic          rst, ld_en, ld_valid, req;
   logic [7:0]    ld_byte;
   logic          ld_ready, ld_full, rd_valid, fault, busy;
   logic [IA-2:0] ld_count;
   logic [IA-1:0] ra;
   logic [W-1:0]  rd;

   imem_bootload #(.INS_ADDRESS(IA), .INS_W(W), .DEPTH(D)) dut (
      .clk(clk), .rst(rst), .ld_en(ld_en), .ld_valid(ld_valid), .ld_byte(ld_byte),
      .ld_ready(ld_ready), .ld_count(ld_count), .ld_full(ld_full),
      .req(req), .ra(ra), .rd(rd), .rd_valid(rd_valid), .fault(fault), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] rd;
      logic        fault;
   } exp_t;

   exp_t        sb[$];
   logic [7:0]  bq[$];
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic fetch(input logic [IA-1:0] a, input logic [31:0] e, input logic f);
      req = 1'b1;
      ra  = a;
      sb.push_back({e, f});
      step();
      req = 1'b0;
   endtask

   task automatic load_bytes();
      ld_en = 1'b1;
      step();
      foreach (bq[i]) begin
         ld_valid = 1'b1;
         ld_byte  = bq[i];
         step();
      end
      check("busy_in_load", {31'd0, busy}, 32'd1);
      ld_valid = 1'b0;
      ld_en    = 1'b0;
      step();
      step();
      step();
      check("busy_after_load", {31'd0, busy}, 32'd0);
   endtask

   // Monitor: every presented fetch must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rd_valid === 1'b1) begin
         exp_t e;
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_fetch: rd_valid with rd=%h fault=%b, expected no fetch", rd, fault);
         end else begin
            e = sb.pop_front();
            check("fetch_rd", rd, e.rd);
            check("fetch_fault", {31'd0, fault}, {31'd0, e.fault});
         end
      end
   end

   initial begin
      rst = 1'b1; ld_en = 1'b0; ld_valid = 1'b0; ld_byte = 8'h00; req = 1'b0; ra = '0;
      step();
      step();
      check("rst_rd", rd, 32'h0);
      check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
      check("rst_fault", {31'd0, fault}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
      check("rst_ld_full", {31'd0, ld_full}, 32'd0);
      check("rst_ld_count", {24'd0, ld_count}, 32'd0);
      rst = 1'b0;
      step();

      // Power-up contents are NOPs.
      fetch(9'h000, 32'h0000_0013, 1'b0);
      step();

      // Two full words; req held with the ld_en rise and through LOAD must not fetch.
      req = 1'b1; ra = 9'h000;
      bq = '{8'h33, 8'h70, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      ld_en = 1'b1;
      step();
      check("ld_ready_in_load", {31'd0, ld_ready}, 32'd1);
      foreach (bq[i]) begin
         ld_valid = 1'b1;
         ld_byte  = bq[i];
         step();
      end
      ld_valid = 1'b0; ld_en = 1'b0; req = 1'b0;
      step(); step(); step();
      check("ld_count_two_words", {24'd0, ld_count}, 32'd2);
      fetch(9'h000, 32'h0000_7033, 1'b0);
      fetch(9'h004, 32'h0010_0093, 1'b0);
      step();

      // One word plus a partial byte: flush zero-fills the upper bytes.
      bq = '{8'h13, 8'h01, 8'h20, 8'h00, 8'hAA};
      load_bytes();
      check("ld_count_flush", {24'd0, ld_count}, 32'd2);
      fetch(9'h004, 32'h0000_00AA, 1'b0);
      fetch(9'h000, 32'h0020_0113, 1'b0);
      fetch(9'h03C, 32'h0000_0013, 1'b0);
      fetch(9'h006, 32'h0000_0013, 1'b1);
      fetch(9'h040, 32'h0000_0013, 1'b1);
      step();
      check("rd_hold_idle", rd, 32'h0000_0013);
      check("rd_valid_idle", {31'd0, rd_valid}, 32'd0);

      // Fill the whole array, then push four extra bytes that must be refused.
      ld_en = 1'b1;
      step();
      for (int k = 0; k < D * 4 + 4; k++) begin
         if (k == D * 4 - 1) check("ld_full_before_last", {31'd0, ld_full}, 32'd0);
         if (k == D * 4) begin
            check("ld_full_set", {31'd0, ld_full}, 32'd1);
            check("ld_ready_when_full", {31'd0, ld_ready}, 32'd0);
            check("ld_count_full", {24'd0, ld_count}, 32'd16);
         end
         ld_valid = 1'b1;
         ld_byte  = (k < D * 4) ? 8'(k) : 8'hEE;
         step();
      end
      ld_valid = 1'b0; ld_en = 1'b0;
      step(); step(); step();
      check("ld_count_after_full", {24'd0, ld_count}, 32'd16);
      fetch(9'h000, 32'h0302_0100, 1'b0);
      fetch(9'h03C, 32'h3f3e_3d3c, 1'b0);
      fetch(9'h040, 32'h0000_0013, 1'b1);
      step();

      // Reset in the middle of a word: partial bytes dropped, earlier words kept.
      ld_en = 1'b1;
      step();
      bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01, 8'h02};
      foreach (bq[i]) begin
         ld_valid = 1'b1;
         ld_byte  = bq[i];
         step();
      end
      ld_valid = 1'b0; ld_en = 1'b0; rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_mid_busy", {31'd0, busy}, 32'd0);
      check("rst_mid_ld_ready", {31'd0, ld_ready}, 32'd0);
      check("rst_mid_ld_count", {24'd0, ld_count}, 32'd0);
      step();
      bq = '{8'h55, 8'h66, 8'h77, 8'h88};
      load_bytes();
      check("ld_count_after_rst", {24'd0, ld_count}, 32'd1);
      fetch(9'h000, 32'h8877_6655, 1'b0);
      fetch(9'h004, 32'hDDCC_BBAA, 1'b0);
      fetch(9'h008, 32'h0b0a_0908, 1'b0);
      step();
      step();

      check("scoreboard_drained", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
